// File: rtl/dds_table_loader.sv
// rtl/dds_table_loader.sv - quarter-wave sine table loader and verifier for the DDS SRAM
//
// Accepts DEPTH samples on a valid/ready stream and writes them to consecutive
// SRAM addresses. It then reads the whole table back and compares the read-back
// sum with the load checksum. On a match it hands the SRAM to the
// phase-to-amplitude read path through pac_en.
//
// Ports:
//   sys_clk   - clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - level; begins a load from IDLE, DONE or ERROR
//   s_valid   - stream sample valid
//   s_data    - stream sample
//   s_ready   - stream ready (high only in LOAD)
//   cen       - SRAM chip enable, active-low
//   wen       - SRAM write enable, active-low (0 write, 1 read)
//   index     - SRAM address
//   data_wr   - SRAM write data
//   sram_q    - SRAM read data, valid the cycle after a read request
//   busy      - load or verify in progress
//   done      - table loaded and verified
//   err       - verify mismatch
//   checksum  - 16-bit wrap-around sum of accepted samples
//   pac_en    - read path may drive the SRAM
module dds_table_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16384
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] data_wr,
  input  logic [DATA_W-1:0] sram_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       checksum,
  output logic              pac_en
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] VERIFY = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERROR  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [15:0]       vsum;
  logic              rd_all;
  // Read pipeline tags: rd_p0 marks a request registered this cycle, rd_p1
  // marks the cycle in which sram_q carries its data. The lst_* chain follows
  // the final request so the compare lands one edge after its accumulation.
  logic              rd_p0, rd_p1;
  logic              lst_0, lst_1, lst_2;

  assign s_ready = (state == LOAD);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cen      <= 1'b1;
      wen      <= 1'b1;
      index    <= '0;
      data_wr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pac_en   <= 1'b0;
      checksum <= '0;
      waddr    <= '0;
      raddr    <= '0;
      vsum     <= '0;
      rd_all   <= 1'b0;
      rd_p0    <= 1'b0;
      rd_p1    <= 1'b0;
      lst_0    <= 1'b0;
      lst_1    <= 1'b0;
      lst_2    <= 1'b0;
    end else begin
      rd_p1 <= rd_p0;
      lst_1 <= lst_0;
      lst_2 <= lst_1;
      case (state)
        IDLE, DONE, ERROR: begin
          cen   <= 1'b1;
          wen   <= 1'b1;
          rd_p0 <= 1'b0;
          lst_0 <= 1'b0;
          if (start) begin
            waddr    <= '0;
            raddr    <= '0;
            checksum <= '0;
            vsum     <= '0;
            rd_all   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            pac_en   <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            cen      <= 1'b0;
            wen      <= 1'b0;
            index    <= waddr;
            data_wr  <= s_data;
            checksum <= checksum + 16'(s_data);
            waddr    <= waddr + 1'b1;
            if (waddr == LAST) state <= VERIFY;
          end else begin
            cen <= 1'b1;
            wen <= 1'b1;
          end
        end
        VERIFY: begin
          if (!rd_all) begin
            cen   <= 1'b0;
            wen   <= 1'b1;
            index <= raddr;
            raddr <= raddr + 1'b1;
            rd_p0 <= 1'b1;
            lst_0 <= (raddr == LAST);
            if (raddr == LAST) rd_all <= 1'b1;
          end else begin
            cen   <= 1'b1;
            wen   <= 1'b1;
            rd_p0 <= 1'b0;
            lst_0 <= 1'b0;
          end
          if (rd_p1) vsum <= vsum + 16'(sram_q);
          // lst_2 is set on the edge that accumulated the final sample, so
          // vsum is complete here.
          if (lst_2) begin
            busy <= 1'b0;
            if (vsum == checksum) begin
              done   <= 1'b1;
              pac_en <= 1'b1;
              state  <= DONE;
            end else begin
              err   <= 1'b1;
              state <= ERROR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_table_loader.sv
// tb/tb_dds_table_loader.sv - self-checking bench for dds_table_loader with DEPTH = 4
module tb_dds_table_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        cen, wen;
  logic [13:0] index;
  logic [15:0] data_wr;
  logic [15:0] sram_q;
  logic        busy, done, err, pac_en;
  logic [15:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  bit corrupt = 1'b0;

  logic [15:0] mem [4];
  logic [31:0] exp_q [$];

  dds_table_loader #(.ADDR_W(14), .DATA_W(16), .DEPTH(4)) dut (
    .sys_clk(clk), .reset(rst_n), .start(start), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .cen(cen), .wen(wen),
    .index(index), .data_wr(data_wr), .sram_q(sram_q), .busy(busy),
    .done(done), .err(err), .checksum(checksum), .pac_en(pac_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM model, optional corruption of address 2 on read.
  logic [15:0] q_r = '0;
  assign sram_q = q_r;
  always @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[index[1:0]] <= data_wr;
      else q_r <= (corrupt && index == 14'd2) ? 16'h2223 : mem[index[1:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every SRAM write must match the next queued sample.
  always @(negedge clk) begin
    if (rst_n && cen === 1'b0 && wen === 1'b0) begin
      wr_cnt++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("write_index", 32'(index), 32'(e[29:16]));
        check("write_data", 32'(data_wr), 32'(e[15:0]));
      end
    end
    if (rst_n) check("pac_en_exclusive", 32'(pac_en && !cen), 32'd0);
  end

  task automatic run_load(input logic [15:0] d [4], input int gap, input bit vstart,
                          input int exp_edge, input bit exp_err, input logic [15:0] exp_sum);
    int c0;
    bit hit;
    wr_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
    check("s_ready_in_load", 32'(s_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int g = 0; g < gap; g++) begin
          s_valid = 1'b0;
          @(negedge clk);
          check("gap_cen", 32'(cen), 32'd1);
        end
      end
      s_valid = 1'b1;
      s_data  = d[i];
      exp_q.push_back({2'b00, 14'(i), d[i]});
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("s_ready_after_load", 32'(s_ready), 32'd0);
    check("busy_verify", 32'(busy), 32'd1);
    if (vstart) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    hit = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done || err) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("finish_seen", 32'(hit), 32'd1);
    check("finish_edge", 32'(cyc - c0), 32'(exp_edge));
    check("done", 32'(done), 32'(!exp_err));
    check("err", 32'(err), 32'(exp_err));
    check("pac_en", 32'(pac_en), 32'(!exp_err));
    check("busy_end", 32'(busy), 32'd0);
    check("checksum", 32'(checksum), 32'(exp_sum));
    check("write_count", 32'(wr_cnt), 32'd4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cen"}, 32'(cen), 32'd1);
    check({tag, "_wen"}, 32'(wen), 32'd1);
    check({tag, "_index"}, 32'(index), 32'd0);
    check({tag, "_data_wr"}, 32'(data_wr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_pac_en"}, 32'(pac_en), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ramp [4];
    logic [15:0] ones [4];
    logic [15:0] sum_hold;
    ramp = '{16'h0000, 16'h1111, 16'h2222, 16'h3333};
    ones = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 4; i++) mem[i] = '0;

    #12;
    check_reset_values("por");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle");

    // Back-to-back load.
    run_load(ramp, 0, 1'b0, 11, 1'b0, 16'h6666);

    // Samples offered in DONE are not accepted.
    sum_hold = checksum;
    s_valid = 1'b1;
    s_data  = 16'h5555;
    repeat (3) @(negedge clk);
    check("done_s_ready", 32'(s_ready), 32'd0);
    check("done_checksum_hold", 32'(checksum), 32'(sum_hold));
    check("done_cen", 32'(cen), 32'd1);
    s_valid = 1'b0;

    // Stalled stream.
    run_load(ramp, 2, 1'b0, 13, 1'b0, 16'h6666);

    // Checksum wrap.
    run_load(ones, 0, 1'b0, 11, 1'b0, 16'hFFFC);

    // Readback corruption, then clean recovery.
    corrupt = 1'b1;
    run_load(ramp, 0, 1'b0, 11, 1'b1, 16'h6666);
    corrupt = 1'b0;
    run_load(ramp, 0, 1'b0, 11, 1'b0, 16'h6666);

    // Start pulsed during VERIFY is ignored.
    run_load(ones, 0, 1'b1, 11, 1'b0, 16'hFFFC);

    // Reset mid-load after 2 samples.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = ramp[i];
      exp_q.push_back({2'b00, 14'(i), ramp[i]});
      @(negedge clk);
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("midload");
    check("midload_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_load(ramp, 0, 1'b0, 11, 1'b0, 16'h6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_table_loader.md
# dds_table_loader

Loads the quarter-wave sine table into the single-port DDS SRAM that the phase-to-amplitude read path uses, and owns the SRAM interface until the table is valid. Samples arrive on a valid/ready stream and are written to consecutive addresses. The block then reads the whole table back, compares checksums, and grants the read path access by asserting `pac_en`. It sits between the host or config stream and the DDS SRAM macro.

## Interface
- `ADDR_W`, 14, SRAM address width.
- `DATA_W`, 16, sample width.
- `DEPTH`, 16384, number of table entries. Range is 2..2^ADDR_W.

- `sys_clk`  in  1  single clock; all logic rises on this edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each edge; starts a load from IDLE, DONE or ERROR.
- `s_valid`  in  1  stream sample valid.
- `s_data`  in  DATA_W  stream sample (two's complement amplitude).
- `s_ready`  out  1  loader accepts a sample this cycle.
- `cen`  out  1  SRAM chip enable, active-low.
- `wen`  out  1  SRAM write enable, active-low. 0 = write, 1 = read.
- `index`  out  ADDR_W  SRAM address.
- `data_wr`  out  DATA_W  SRAM write data.
- `sram_q`  in  DATA_W  SRAM read data; valid the cycle after a read request.
- `busy`  out  1  LOAD or VERIFY in progress.
- `done`  out  1  table loaded and verified.
- `err`  out  1  verify mismatch.
- `checksum`  out  16  modulo-2^16 sum of accepted samples.
- `pac_en`  out  1  read path may drive the SRAM.

## Operation
- States are IDLE, LOAD, VERIFY, DONE and ERROR. The state register and all outputs are registered. The exception is `s_ready`, which equals (state == LOAD).
- Reset values:
  - state IDLE.
  - `cen` = 1, `wen` = 1, `index` = 0, `data_wr` = 0.
  - `busy`, `done`, `err`, `pac_en`, `checksum` all 0.
- **IDLE, DONE, ERROR:** `cen` = 1 and `wen` = 1. When `start` = 1:
  - clear `waddr`, `raddr`, `checksum`, the verify sum `vsum`, `done`, `err` and `pac_en`;
  - set `busy`;
  - go to LOAD.
- **LOAD:** each edge with `s_valid` & `s_ready` does the following:
  - registers `cen` = 0, `wen` = 0, `index` = `waddr`, `data_wr` = `s_data`;
  - adds `s_data` to `checksum`;
  - increments `waddr`.
  
  An edge with no handshake registers `cen` = 1, `wen` = 1. The handshake at `waddr` = DEPTH-1 moves the state to VERIFY.
- **VERIFY:** each edge registers a read request (`cen` = 0, `wen` = 1, `index` = `raddr`) and increments `raddr`. This repeats for `raddr` 0..DEPTH-1; after that `cen` returns to 1.
  - `sram_q` is added to `vsum` (mod 2^16) on the edge two edges after its request edge.
  - After the last sample is accumulated, the next edge compares `vsum` with `checksum`:
    - equal: go to DONE with `done` = 1 and `pac_en` = 1;
    - not equal: go to ERROR with `err` = 1.
  - In both cases `busy` = 0.
- `start` during LOAD or VERIFY is ignored.
- Samples offered outside LOAD are not accepted and have no effect.
- Arithmetic:
  - `checksum` and `vsum` are 16-bit unsigned wrap-around sums. The sign bit gets no special treatment.
  - `waddr` and `raddr` are ADDR_W wide. They never wrap, because the state changes at DEPTH-1.
- Reset mid-operation: state returns to IDLE with reset values, including `pac_en` = 0. The table is invalid until a full load completes.

## Timing
- `start` sampled at edge 0 gives LOAD from edge 0.
- With `s_valid` held high, handshakes occur at edges 1..DEPTH.
- Each SRAM write happens at the edge after its handshake.
- `done` (or `err`) rises at edge 2·DEPTH+3 and stays until the next accepted `start` or reset. Each cycle of `s_valid` low during LOAD delays it by one cycle.
- `s_ready` falls immediately after the last handshake edge, so exactly DEPTH samples are accepted per load.
- `pac_en` is 0 at all times while `cen` or `wen` is driven by this block.

## Test plan
- **Reset values:** assert `reset` = 0 asynchronously mid-cycle → all outputs take reset values immediately and `s_ready` = 0.
- **Back-to-back load:** DEPTH = 4, samples 0x0000, 0x1111, 0x2222, 0x3333 with `s_valid` always high → writes to `index` 0..3 with matching `data_wr`, then reads 0..3. Expected `checksum` = 0x6666, `done` = 1 and `pac_en` = 1 at edge 11, `err` = 0.
- **Stalled stream:** same samples with `s_valid` low for 2 cycles between samples 1 and 2 → no write in the gap cycles (`cen` = 1), and `done` rises at edge 13.
- **Checksum wrap:** DEPTH = 4, four samples of 0xFFFF → `checksum` = 0xFFFC and `done` = 1.
- **Readback corruption:** SRAM model returns 0x2223 at address 2 → `err` = 1, `done` = 0, `pac_en` = 0. A following `start` with a clean model reaches DONE.
- **Reset and ignored start:** `start` pulsed during VERIFY is ignored. Reset during LOAD after 2 samples, then a new full load → exactly 4 fresh writes and correct `done`.
